// File: rtl/phase_seq.sv
// phase_seq: one-hot instruction-phase sequencer for the multi-cycle CPU core.
//
// Steps the core through N_PH phases. Phases can be skipped, the current phase
// can be stalled, and the core can halt and later restart. Every completed
// pass back to phase 0 retires one instruction, which is counted.
// Sequencing starts SYNC_DEPTH rising edges after n_rst is released.
//
// Ports
//   clk         in   1      clock, rising edge
//   n_rst       in   1      asynchronous active-low reset
//   hlt         in   1      halt request (RUN only)
//   stall       in   1      hold the current phase
//   run         in   1      restart request (HALT only)
//   skip        in   N_PH   skip[i]=1 bypasses phase i on advance; skip[0] has no effect
//   phase       out  N_PH   one-hot current phase, zero when idle/halted
//   ph_idx      out  IDX_W  binary index of the active phase, 0 when idle/halted
//   halted      out  1      high while halted
//   instr_done  out  1      one-cycle pulse, coincident with phase 0 after a wrap
//   instr_cnt   out  CNT_W  retired instructions since reset, wraps
module phase_seq #(
  parameter  int N_PH       = 5,
  parameter  int SYNC_DEPTH = 3,
  parameter  int CNT_W      = 16,
  localparam int IDX_W      = $clog2(N_PH)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             hlt,
  input  logic             stall,
  input  logic             run,
  input  logic [N_PH-1:0]  skip,
  output logic [N_PH-1:0]  phase,
  output logic [IDX_W-1:0] ph_idx,
  output logic             halted,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [N_PH-1:0]       phase_q, phase_d;
  logic                  instr_done_q, instr_done_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SYNC_DEPTH-1:0] sync_q, sync_d;

  logic                  start;
  logic [IDX_W-1:0]      cur_idx;
  logic [IDX_W-1:0]      nxt_idx;
  logic                  wrap;

  // Reset-release synchroniser: ones shift in after n_rst deasserts. The
  // 01 pattern at the top appears for exactly one cycle, so start is a pulse.
  assign sync_d = {sync_q[SYNC_DEPTH-2:0], 1'b1};
  assign start  = (sync_q[SYNC_DEPTH-1:SYNC_DEPTH-2] == 2'b01);

  // One-hot to binary; all-zero phase encodes to 0.
  always_comb begin
    cur_idx = '0;
    for (int i = 0; i < N_PH; i++) begin
      if (phase_q[i]) cur_idx = IDX_W'(i);
    end
  end

  // Lowest unskipped phase above the current one; the descending scan leaves
  // the lowest match last. j=0 can never exceed cur_idx, so skip[0] is inert
  // and "no match" falls out as index 0, i.e. a wrap.
  always_comb begin
    nxt_idx = '0;
    for (int j = N_PH - 1; j >= 0; j--) begin
      if (!skip[j] && (j > int'(cur_idx))) nxt_idx = IDX_W'(j);
    end
  end

  assign wrap = (nxt_idx == '0);

  // NOTE: every signal this block drives gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    instr_done_d = 1'b0;
    cnt_d        = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          phase_d = N_PH'(1);
        end
      end
      ST_RUN: begin
        // hlt wins over stall, stall wins over advance.
        if (hlt) begin
          state_d = ST_HALT;
          phase_d = '0;
        end else if (!stall) begin
          phase_d = N_PH'(1) << nxt_idx;
          if (wrap) begin
            instr_done_d = 1'b1;
            cnt_d        = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_HALT: begin
        if (run) begin
          state_d = ST_RUN;
          phase_d = N_PH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      instr_done_q <= 1'b0;
      cnt_q        <= '0;
      sync_q       <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      instr_done_q <= instr_done_d;
      cnt_q        <= cnt_d;
      sync_q       <= sync_d;
    end
  end

  assign phase      = phase_q;
  assign ph_idx     = cur_idx;
  assign halted     = (state_q == ST_HALT);
  assign instr_done = instr_done_q;
  assign instr_cnt  = cnt_q;

endmodule
